// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: character-in / serial-out signal bundle for the UART transmitter.
// The afe_in/cts_in pair only exists when UART_TX_AFE_EN is defined.
interface uart_tx_ctrl_if;
  logic       bclk_tick_in;
  logic       tx_en_in;
  logic       thr_valid_in;
  logic [7:0] thr_data_in;
  logic       thr_pop_out;
  logic [1:0] wls_in;
  logic       stb_in;
  logic       pen_in;
  logic       eps_in;
  logic       sp_in;
  logic       bc_in;
`ifdef UART_TX_AFE_EN
  logic       afe_in;
  logic       cts_in;
`endif
  logic       uart_txd_out;
  logic       tx_busy_out;
  logic       temt_out;

  modport master (
`ifdef UART_TX_AFE_EN
    output afe_in,
    output cts_in,
`endif
    output bclk_tick_in,
    output tx_en_in,
    output thr_valid_in,
    output thr_data_in,
    output wls_in,
    output stb_in,
    output pen_in,
    output eps_in,
    output sp_in,
    output bc_in,
    input  thr_pop_out,
    input  uart_txd_out,
    input  tx_busy_out,
    input  temt_out
  );

  modport slave (
`ifdef UART_TX_AFE_EN
    input  afe_in,
    input  cts_in,
`endif
    input  bclk_tick_in,
    input  tx_en_in,
    input  thr_valid_in,
    input  thr_data_in,
    input  wls_in,
    input  stb_in,
    input  pen_in,
    input  eps_in,
    input  sp_in,
    input  bc_in,
    output thr_pop_out,
    output uart_txd_out,
    output tx_busy_out,
    output temt_out
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer. Pulls one character per frame from the
// holding register, serialises start/data/parity/stop at OVERSAMPLE bclk ticks per bit.
// Optional build macro UART_TX_AFE_EN: auto flow control (afe_in/cts_in) gates frame starts.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// ST_IDLE   | line high, waiting for a character on a bclk tick
// ST_START  | start bit (low), OVERSAMPLE ticks
// ST_DATA   | wls+5 data bits, LSB first
// ST_PARITY | one parity bit (only when parity was enabled at frame start)
// ST_STOP   | stop bit(s): 1, 1.5 or 2 bit times; may chain straight into START
module uart_tx_ctrl #(
  parameter int OVERSAMPLE = 16
) (
  input  logic          apb_clk_in,
  input  logic          apb_rst_in,
  uart_tx_ctrl_if.slave tx_if
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [3:0] TC_FULL = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TC_HALF = 4'(OVERSAMPLE / 2 - 1);

  state_t     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_second_q, stop_second_d;
  logic       txd_q, txd_d;
  logic [7:0] data_q;
  logic [1:0] wls_q;
  logic       stb_q, pen_q, eps_q, sp_q;
  logic       flow_ok, start_ok, pop;
  logic       bit_end, last_bit, stop_first_end, stop_end;
  logic [3:0] stop_tc;
  logic [7:0] data_mask;
  logic       par_xor, parity_bit;

`ifdef UART_TX_AFE_EN
  assign flow_ok = ~(tx_if.afe_in & ~tx_if.cts_in);
`else
  assign flow_ok = 1'b1;
`endif

  // reset gate keeps the combinational pop quiet while apb_rst_in is high
  assign start_ok = ~apb_rst_in & tx_if.bclk_tick_in & tx_if.tx_en_in &
                    tx_if.thr_valid_in & flow_ok;

  assign bit_end        = tx_if.bclk_tick_in & (tick_cnt_q == TC_FULL);
  assign last_bit       = (bit_idx_q == ({1'b0, wls_q} + 3'd4));
  // second stop period is a half bit only for 5-bit words with stb set
  assign stop_tc        = (wls_q == 2'd0) ? TC_HALF : TC_FULL;
  assign stop_first_end = bit_end & ~stop_second_q & stb_q;
  assign stop_end       = tx_if.bclk_tick_in &
                          (stop_second_q ? (tick_cnt_q == stop_tc)
                                         : (~stb_q & (tick_cnt_q == TC_FULL)));

  assign data_mask  = 8'hFF >> (2'd3 - wls_q);
  assign par_xor    = ^(data_q & data_mask);
  assign parity_bit = sp_q ? ~eps_q : (eps_q ? par_xor : ~par_xor);

  // State register
  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state, pop strobe and the next line level
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (!tx_if.tx_en_in) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_d = ST_START;
            pop     = 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) state_d = ST_DATA;
        end
        ST_DATA: begin
          if (bit_end && last_bit) state_d = pen_q ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (bit_end) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (stop_end) begin
            if (start_ok) begin
              state_d = ST_START;
              pop     = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = data_q[bit_idx_d];
      ST_PARITY: txd_d = parity_bit;
      default:   txd_d = 1'b1;
    endcase
  end

  // Tick counter, bit index and stop-phase flag next values
  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    bit_idx_d     = bit_idx_q;
    stop_second_d = stop_second_q;
    if (!tx_if.tx_en_in || state_q == ST_IDLE) begin
      tick_cnt_d    = 4'd0;
      bit_idx_d     = 3'd0;
      stop_second_d = 1'b0;
    end else begin
      if (tx_if.bclk_tick_in) begin
        tick_cnt_d = ((tick_cnt_q == TC_FULL) || stop_end) ? 4'd0 : tick_cnt_q + 4'd1;
      end
      if (state_q != ST_DATA)            bit_idx_d = 3'd0;
      else if (bit_end && !last_bit)     bit_idx_d = bit_idx_q + 3'd1;
      if (state_q != ST_STOP || stop_end) stop_second_d = 1'b0;
      else if (stop_first_end)           stop_second_d = 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      tick_cnt_q    <= 4'd0;
      bit_idx_q     <= 3'd0;
      stop_second_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      bit_idx_q     <= bit_idx_d;
      stop_second_q <= stop_second_d;
    end
  end

  // Registered serial line; break overrides whatever the FSM wants to send
  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) txd_q <= 1'b1;
    else            txd_q <= tx_if.bc_in ? 1'b0 : txd_d;
  end

  // Character and frame format captured on the pop so mid-frame changes wait a frame
  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      data_q <= 8'h00;
      wls_q  <= 2'd0;
      stb_q  <= 1'b0;
      pen_q  <= 1'b0;
      eps_q  <= 1'b0;
      sp_q   <= 1'b0;
    end else if (pop) begin
      data_q <= tx_if.thr_data_in;
      wls_q  <= tx_if.wls_in;
      stb_q  <= tx_if.stb_in;
      pen_q  <= tx_if.pen_in;
      eps_q  <= tx_if.eps_in;
      sp_q   <= tx_if.sp_in;
    end
  end

  assign tx_if.thr_pop_out  = pop;
  assign tx_if.uart_txd_out = txd_q;
  assign tx_if.tx_busy_out  = (state_q != ST_IDLE);
  assign tx_if.temt_out     = (state_q == ST_IDLE) & ~tx_if.thr_valid_in;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed frames against uart_tx_ctrl with OVERSAMPLE=16.
// bclk ticks arrive every 4th clock; the line is sampled once per tick edge.
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_ctrl_if tx_if ();

  uart_tx_ctrl #(.OVERSAMPLE(16)) dut (
    .apb_clk_in (clk),
    .apb_rst_in (rst),
    .tx_if      (tx_if)
  );

  int checks = 0;
  int errors = 0;

  localparam int CAPN = 400;
  logic cap_line [CAPN];
  logic cap_busy [CAPN];
  logic cap_temt [CAPN];
  int   pop_idx [$];
  bit   cap_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // tick generator, driven away from the sampling negedge
  int tick_div = 0;
  initial begin
    tx_if.bclk_tick_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_if.bclk_tick_in = (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] seg(input int start, input int len);
    logic [31:0] v = '0;
    for (int i = 0; i < len; i++) v[i] = cap_line[start + i];
    return v;
  endfunction

  function automatic logic [31:0] fill(input logic b, input int len);
    logic [31:0] v = '0;
    for (int i = 0; i < len; i++) v[i] = b;
    return v;
  endfunction

  task automatic set_cfg(input logic [1:0] w, input logic s, input logic p,
                         input logic e, input logic st);
    tx_if.wls_in = w;
    tx_if.stb_in = s;
    tx_if.pen_in = p;
    tx_if.eps_in = e;
    tx_if.sp_in  = st;
  endtask

  // called at a negedge; returns at the negedge where pop is high
  task automatic wait_pop(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (tx_if.thr_pop_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // cap_*[k] = values after tick edge k, edge 0 being the pop edge
  task automatic capture(input int n, input logic nv_valid, input logic [7:0] nv_data,
                         input bit scramble, input int bc_on, input int bc_off);
    int k   = 0;
    int cyc = 0;
    bit pend = 1'b1;
    bit drop = 1'b0;
    pop_idx.delete();
    pop_idx.push_back(0);
    cap_ok = 1'b1;
    while (k < n) begin
      @(negedge clk);
      cyc++;
      if (cyc > n * 8 + 100) begin
        cap_ok = 1'b0;
        break;
      end
      if (drop) begin
        tx_if.thr_valid_in = 1'b0;
        drop = 1'b0;
      end
      if (pend) begin
        cap_line[k] = tx_if.uart_txd_out;
        cap_busy[k] = tx_if.tx_busy_out;
        cap_temt[k] = tx_if.temt_out;
        if (k == 0) begin
          tx_if.thr_valid_in = nv_valid;
          tx_if.thr_data_in  = nv_data;
          if (scramble) begin
            tx_if.wls_in = ~tx_if.wls_in;
            tx_if.pen_in = ~tx_if.pen_in;
            tx_if.stb_in = ~tx_if.stb_in;
            tx_if.eps_in = ~tx_if.eps_in;
          end
        end
        if (k == bc_on)  tx_if.bc_in = 1'b1;
        if (k == bc_off) tx_if.bc_in = 1'b0;
        k++;
      end
      #1;
      pend = tx_if.bclk_tick_in;
      if (pend && tx_if.thr_pop_out === 1'b1) begin
        pop_idx.push_back(k);
        drop = 1'b1;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] data,
                             input int nbits, input bit has_par, input logic par,
                             input int stop_ticks);
    int off = base;
    chk({tag, "_busy_first"}, 32'(cap_busy[base]), 32'd1);
    chk({tag, "_start"}, seg(off, 16), fill(1'b0, 16));
    off += 16;
    for (int i = 0; i < nbits; i++) begin
      chk($sformatf("%s_d%0d", tag, i), seg(off, 16), fill(data[i], 16));
      off += 16;
    end
    if (has_par) begin
      chk({tag, "_par"}, seg(off, 16), fill(par, 16));
      off += 16;
    end
    chk({tag, "_stop"}, seg(off, stop_ticks), fill(1'b1, stop_ticks));
    off += stop_ticks;
    chk({tag, "_busy_last"}, 32'(cap_busy[off - 1]), 32'd1);
  endtask

  task automatic single_frame(input string tag, input logic [7:0] data, input int nbits,
                              input bit has_par, input logic par, input int stop_ticks,
                              input bit scramble);
    bit ok;
    int len = 16 * (1 + nbits + (has_par ? 1 : 0)) + stop_ticks;
    @(negedge clk);
    tx_if.thr_data_in  = data;
    tx_if.thr_valid_in = 1'b1;
    wait_pop(200, ok);
    chk({tag, "_pop_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      capture(len + 1, 1'b0, 8'hA6, scramble, -1, -1);
      chk({tag, "_cap"}, 32'(cap_ok), 32'd1);
      check_frame(tag, 0, data, nbits, has_par, par, stop_ticks);
      chk({tag, "_idle_line"}, 32'(cap_line[len]), 32'd1);
      chk({tag, "_idle_busy"}, 32'(cap_busy[len]), 32'd0);
      chk({tag, "_pops"}, pop_idx.size(), 32'd1);
    end
  endtask

  initial begin
    bit ok;
    bit found;
    int pops;
    int temt_ones;

    rst = 1'b1;
    tx_if.tx_en_in     = 1'b1;
    tx_if.thr_valid_in = 1'b1;
    tx_if.thr_data_in  = 8'h00;
    tx_if.bc_in        = 1'b0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UART_TX_AFE_EN
    tx_if.afe_in = 1'b0;
    tx_if.cts_in = 1'b1;
`endif

    // reset: a qualifying tick during reset must not pop
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (tx_if.bclk_tick_in) found = 1'b1;
    end
    chk("rst_tick_seen", 32'(found), 32'd1);
    chk("rst_pop", 32'(tx_if.thr_pop_out), 32'd0);
    chk("rst_txd", 32'(tx_if.uart_txd_out), 32'd1);
    chk("rst_busy", 32'(tx_if.tx_busy_out), 32'd0);
    tx_if.thr_valid_in = 1'b0;
    #1;
    chk("rst_temt", 32'(tx_if.temt_out), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_txd", 32'(tx_if.uart_txd_out), 32'd1);
    chk("idle_temt", 32'(tx_if.temt_out), 32'd1);

    // 8N1 0x55, config scrambled right after the pop
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    single_frame("a", 8'h55, 8, 1'b0, 1'b0, 16, 1'b1);

    // 5 bits, even parity, 1.5 stop: 0x13 -> 1,1,0,0,1 par 1, 24 stop ticks
    set_cfg(2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    single_frame("b", 8'h13, 5, 1'b1, 1'b1, 24, 1'b0);

    // 6 bits, odd parity, 2 stop: 0xEB low bits 101011 (four ones) -> parity 1
    set_cfg(2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    single_frame("c", 8'hEB, 6, 1'b1, 1'b1, 32, 1'b0);

    // 7 bits, stick parity with eps=1 -> parity 0, 1 stop
    set_cfg(2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    single_frame("d", 8'h7F, 7, 1'b1, 1'b0, 16, 1'b0);

    // two queued characters, 8N2: back-to-back frames of 176 ticks
    set_cfg(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tx_if.thr_data_in  = 8'hA5;
    tx_if.thr_valid_in = 1'b1;
    wait_pop(200, ok);
    chk("q_pop_seen", 32'(ok), 32'd1);
    if (ok) begin
      capture(353, 1'b1, 8'h3C, 1'b0, -1, -1);
      chk("q_cap", 32'(cap_ok), 32'd1);
      check_frame("q1", 0, 8'hA5, 8, 1'b0, 1'b0, 32);
      chk("q_pops", pop_idx.size(), 32'd2);
      chk("q_pop2_idx", (pop_idx.size() > 1) ? 32'(pop_idx[1]) : 32'hFFFF_FFFF, 32'd176);
      check_frame("q2", 176, 8'h3C, 8, 1'b0, 1'b0, 32);
      temt_ones = 0;
      for (int i = 0; i < 352; i++) if (cap_temt[i] === 1'b1) temt_ones++;
      chk("q_temt_early", temt_ones, 32'd0);
      chk("q_temt_end", 32'(cap_temt[352]), 32'd1);
      chk("q_busy_end", 32'(cap_busy[352]), 32'd0);
    end

    // enable dropped during data bit 3, then re-enabled with a fresh pop
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tx_if.thr_data_in  = 8'h00;
    tx_if.thr_valid_in = 1'b1;
    wait_pop(200, ok);
    chk("e_pop_seen", 32'(ok), 32'd1);
    if (ok) begin
      capture(71, 1'b1, 8'h0F, 1'b0, -1, -1);
      chk("e_cap", 32'(cap_ok), 32'd1);
      chk("e_bit3_low", seg(64, 7), 32'd0);
      tx_if.tx_en_in = 1'b0;
      @(negedge clk);
      chk("e_off_txd", 32'(tx_if.uart_txd_out), 32'd1);
      chk("e_off_busy", 32'(tx_if.tx_busy_out), 32'd0);
      pops = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (tx_if.thr_pop_out === 1'b1) pops++;
      end
      chk("e_off_pops", pops, 32'd0);
      chk("e_off_txd2", 32'(tx_if.uart_txd_out), 32'd1);
      tx_if.tx_en_in = 1'b1;
      wait_pop(200, ok);
      chk("e_repop", 32'(ok), 32'd1);
      if (ok) begin
        capture(161, 1'b0, 8'h00, 1'b0, -1, -1);
        check_frame("r", 0, 8'h0F, 8, 1'b0, 1'b0, 16);
        chk("r_idle_busy", 32'(cap_busy[160]), 32'd0);
      end
    end

    // break held for 40 ticks in the middle of an all-ones frame
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tx_if.thr_data_in  = 8'hFF;
    tx_if.thr_valid_in = 1'b1;
    wait_pop(200, ok);
    chk("k_pop_seen", 32'(ok), 32'd1);
    if (ok) begin
      capture(161, 1'b0, 8'h00, 1'b0, 40, 80);
      chk("k_cap", 32'(cap_ok), 32'd1);
      chk("k_start", seg(0, 16), fill(1'b0, 16));
      chk("k_pre", seg(16, 25), fill(1'b1, 25));
      chk("k_low1", seg(41, 20), 32'd0);
      chk("k_low2", seg(61, 20), 32'd0);
      chk("k_post1", seg(81, 32), fill(1'b1, 32));
      chk("k_post2", seg(113, 32), fill(1'b1, 32));
      chk("k_tail", seg(145, 16), fill(1'b1, 16));
      chk("k_busy_last", 32'(cap_busy[159]), 32'd1);
      chk("k_busy_end", 32'(cap_busy[160]), 32'd0);
      chk("k_pops", pop_idx.size(), 32'd1);
    end

`ifdef UART_TX_AFE_EN
    // flow control: cts low holds the next start, cts high starts on the next tick
    tx_if.afe_in = 1'b1;
    tx_if.cts_in = 1'b1;
    @(negedge clk);
    tx_if.thr_data_in  = 8'h11;
    tx_if.thr_valid_in = 1'b1;
    wait_pop(200, ok);
    chk("f_pop_seen", 32'(ok), 32'd1);
    if (ok) begin
      @(negedge clk);
      tx_if.cts_in      = 1'b0;
      tx_if.thr_data_in = 8'h22;
      pops  = 0;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
        @(negedge clk);
        if (tx_if.thr_pop_out === 1'b1) pops++;
        if (tx_if.tx_busy_out === 1'b0) found = 1'b1;
      end
      chk("f_frame_done", 32'(found), 32'd1);
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (tx_if.thr_pop_out === 1'b1) pops++;
        if (tx_if.uart_txd_out !== 1'b1) found = 1'b0;
      end
      chk("f_held_pops", pops, 32'd0);
      chk("f_held_line", 32'(found), 32'd1);
      tx_if.cts_in = 1'b1;
      wait_pop(5, ok);
      chk("f_cts_start", 32'(ok), 32'd1);
      tx_if.thr_valid_in = 1'b0;
      repeat (800) @(negedge clk);
      tx_if.afe_in = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
